// File: rtl/coso_uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | coso_uart_pkg: shared state encodings and constants for UART TX.   |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package coso_uart_pkg;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_e;

    localparam int unsigned UART_DATA_BITS            = 8;
    localparam int unsigned UART_CLKS_PER_BIT_DEFAULT = 16;
    localparam int unsigned UART_BIT_CNT_W            = 16;

endpackage : coso_uart_pkg
`default_nettype wire

// File: rtl/uart_tx_serializer_baud_tick_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | baud_tick_gen: down-counter emitting a one-cycle bit-end pulse     |
// | every CLKS_PER_BIT cycles; synchronous clear reloads it. rev 1.0   |
// +--------------------------------------------------------------------+
module baud_tick_gen
    import coso_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear_i,
    output logic bit_end_o
);

    localparam logic [UART_BIT_CNT_W-1:0] RELOAD = UART_BIT_CNT_W'(CLKS_PER_BIT - 1);

    logic [UART_BIT_CNT_W-1:0] cnt_q;
    logic [UART_BIT_CNT_W-1:0] cnt_d;
    logic                      cnt_zero;

    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q - 1'b1;
        if (clear_i || cnt_zero) begin
            cnt_d = RELOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A clear cycle never reports a boundary, so a stale zero after reset is harmless.
    assign bit_end_o = cnt_zero && !clear_i;

endmodule : baud_tick_gen
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_tx_serializer: 8N1 (or 8N2) UART byte transmitter with a      |
// | registered busy flag pacing the upstream packet FSM. rev 1.0       |
// +--------------------------------------------------------------------+
module uart_tx_serializer
    import coso_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       transmit,
    input  logic [7:0] tx_byte,
    output logic       tx,
    output logic       is_transmitting
);

    localparam logic [2:0] LAST_DATA_BIT = 3'(UART_DATA_BITS - 1);
    localparam logic       LAST_STOP_BIT = 1'(STOP_BITS - 1);

    uart_state_e state_q;
    logic [7:0]  shift_q;
    logic [2:0]  bit_idx_q;
    logic        stop_idx_q;
    logic        tx_q;
    logic        busy_q;
    logic        bit_end;
    logic        tick_clear;

    // Holding the tick generator in clear while idle aligns its first pulse with the start bit.
    assign tick_clear = (state_q == UART_IDLE);

    baud_tick_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick_gen (
        .clk       (clk),
        .rstn      (rstn),
        .clear_i   (tick_clear),
        .bit_end_o (bit_end)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= UART_IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                UART_IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    if (transmit) begin
                        shift_q <= tx_byte;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= UART_START;
                    end
                end
                UART_START: begin
                    if (bit_end) begin
                        tx_q      <= shift_q[0];
                        bit_idx_q <= '0;
                        state_q   <= UART_DATA;
                    end
                end
                UART_DATA: begin
                    if (bit_end) begin
                        if (bit_idx_q == LAST_DATA_BIT) begin
                            tx_q       <= 1'b1;
                            stop_idx_q <= 1'b0;
                            state_q    <= UART_STOP;
                        end else begin
                            shift_q   <= shift_q >> 1;
                            tx_q      <= shift_q[1];
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end
                UART_STOP: begin
                    if (bit_end) begin
                        if (stop_idx_q == LAST_STOP_BIT) begin
                            busy_q  <= 1'b0;
                            state_q <= UART_IDLE;
                        end else begin
                            stop_idx_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= UART_IDLE;
                end
            endcase
        end
    end

    assign tx              = tx_q;
    assign is_transmitting = busy_q;

endmodule : uart_tx_serializer
`default_nettype wire
